// File: rtl/pdm_audio_pkg.sv
// Shared constants for the PDM audio path (decimator and pcm_to_pdm).
// PCM width, default decimation, offset constant and a clog2 helper.
package pdm_audio_pkg;

  localparam int PCM_W          = 16;
  localparam int DEF_DECIMATION = 64;
  localparam int PCM_OFFSET     = 1 << (PCM_W - 1);

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sd_mod1.sv
// First-order sigma-delta core: acc plus offset input, carry is the bit.
// Ports: pdm_clk, reset_n, en, x (signed W), pdm (registered bit).
module sd_mod1
  import pdm_audio_pkg::*;
#(
  parameter int W = PCM_W
) (
  input  logic                pdm_clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic signed [W-1:0] x,
  output logic                pdm
);

  logic [W-1:0] acc;
  logic [W-1:0] u;
  logic [W:0]   s;

  // Adding 2^(W-1) mod 2^W is just an MSB flip.
  always_comb begin
    u = {~x[W-1], x[W-2:0]};
    s = {1'b0, acc} + {1'b0, u};
  end

  always_ff @(posedge pdm_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      pdm <= 1'b0;
    end else if (en) begin
      acc <= s[W-1:0];
      pdm <= s[W];
    end
  end

endmodule

// File: rtl/pcm_to_pdm.sv
// PCM sample stream to 1-bit PDM, with handshake, phase and pcm_clk.
// Ports: pdm_clk, reset_n, pcm/pcm_valid/pcm_ready, pdm, pcm_clk,
// underrun. Macro PCM_TO_PDM_INTERP_LINEAR_EN adds linear interpolation.
module pcm_to_pdm
  import pdm_audio_pkg::*;
#(
  parameter int DECIMATION = DEF_DECIMATION,
  parameter int PCM_W      = pdm_audio_pkg::PCM_W
) (
  input  logic                    pdm_clk,
  input  logic                    reset_n,
  input  logic signed [PCM_W-1:0] pcm,
  input  logic                    pcm_valid,
  output logic                    pcm_ready,
  output logic                    pdm,
  output logic                    pcm_clk,
  output logic                    underrun
);

  localparam int L = clog2(DECIMATION);
  localparam logic [L-1:0] PH_LAST = L'(DECIMATION - 1);
  localparam logic [L-1:0] PH_MID  = L'(DECIMATION / 2);

  logic [L-1:0]             phase;
  logic                     bnd;
  logic                     xfer;
  logic                     ld;
  logic                     buf_full;
  logic signed [PCM_W-1:0]  pbuf;
  logic signed [PCM_W-1:0]  x;

  assign pcm_ready = !buf_full;
  assign bnd       = (phase == PH_LAST);
  assign xfer      = pcm_valid && !buf_full;
  assign ld        = bnd && buf_full;

  always_ff @(posedge pdm_clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= '0;
      buf_full <= 1'b0;
      pbuf     <= '0;
      underrun <= 1'b0;
      pcm_clk  <= 1'b0;
    end else begin
      phase    <= phase + 1'b1;
      underrun <= bnd && !buf_full;
      // An empty-buffer boundary may still accept a sample.
      if (ld) begin
        buf_full <= 1'b0;
      end else if (xfer) begin
        buf_full <= 1'b1;
        pbuf     <= pcm;
      end
      if (bnd) begin
        pcm_clk <= 1'b0;
      end else if (phase == PH_MID) begin
        pcm_clk <= 1'b1;
      end
    end
  end

`ifdef PCM_TO_PDM_INTERP_LINEAR_EN
  logic signed [PCM_W-1:0]   prev;
  logic signed [PCM_W:0]     step;
  logic signed [PCM_W+L-1:0] xs;

  always_ff @(posedge pdm_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
      step <= '0;
      xs   <= '0;
    end else begin
      xs <= xs + {{(L-1){step[PCM_W]}}, step};
      if (ld) begin
        step <= {pbuf[PCM_W-1], pbuf}
              - {prev[PCM_W-1], prev};
        prev <= pbuf;
      end else if (bnd) begin
        step <= '0;
      end
    end
  end

  // xs carries DECIMATION times the sample; drop the fraction.
  assign x = xs[PCM_W+L-1:L];
`else
  logic signed [PCM_W-1:0] cur;

  always_ff @(posedge pdm_clk or negedge reset_n) begin
    if (!reset_n) begin
      cur <= '0;
    end else if (ld) begin
      cur <= pbuf;
    end
  end

  assign x = cur;
`endif

  sd_mod1 #(
    .W (PCM_W)
  ) u_mod (
    .pdm_clk (pdm_clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .x       (x),
    .pdm     (pdm)
  );

endmodule

// File: tb/tb_pcm_to_pdm.sv
// Scoreboard bench for pcm_to_pdm (zero-order hold build).
// Inputs change on negedge; outputs sampled on the next negedge.
module tb_pcm_to_pdm;
  import pdm_audio_pkg::*;

  localparam int D = 64;

  logic               pdm_clk = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [15:0] pcm = '0;
  logic               pcm_valid = 1'b0;
  logic               pcm_ready;
  logic               pdm;
  logic               pcm_clk;
  logic               underrun;

  always #5 pdm_clk = ~pdm_clk;

  pcm_to_pdm #(
    .DECIMATION (D),
    .PCM_W      (16)
  ) dut (
    .pdm_clk   (pdm_clk),
    .reset_n   (reset_n),
    .pcm       (pcm),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .pdm       (pdm),
    .pcm_clk   (pcm_clk),
    .underrun  (underrun)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference state: accepted samples wait in q until a boundary.
  int     ph;
  int     cur_m;
  int     q[$];
  longint sum_u;
  longint ones;
  bit     exp_ur;
  bit     exp_pclk;
  int     ur_cnt;

  task automatic model_reset();
    ph       = 0;
    cur_m    = 0;
    q.delete();
    sum_u    = 0;
    ones     = 0;
    exp_pclk = 0;
  endtask

  task automatic tick(input bit v, input int val, output bit took);
    bit bnd;
    int vv;
    vv        = val;
    pcm_valid = v;
    pcm       = vv[15:0];
    chk("ready", pcm_ready, q.size() == 0);
    took   = v && (q.size() == 0);
    bnd    = (ph == D - 1);
    sum_u += cur_m + PCM_OFFSET;
    exp_ur = 0;
    if (bnd) begin
      if (q.size() != 0) cur_m = q.pop_front();
      else exp_ur = 1;
    end
    if (took) q.push_back(val);
    if (bnd) exp_pclk = 0;
    else if (ph == D / 2) exp_pclk = 1;
    ph = (ph + 1) % D;
    @(posedge pdm_clk);
    @(negedge pdm_clk);
    ones += pdm;
    if (underrun) ur_cnt++;
    chk("underrun", underrun, exp_ur);
    chk("pcm_clk", pcm_clk, exp_pclk);
    // Carry-out count equals floor(sum of offset inputs / 2^16).
    if (bnd) chk("ones_total", ones, sum_u >> 16);
  endtask

  task automatic run_seg(input string tag, input int val,
                         input int np, input int from,
                         input int exp_ones);
    bit     t;
    longint o0;
    for (int p = 0; p < np; p++) begin
      o0 = ones;
      for (int c = 0; c < D; c++) tick(1'b1, val, t);
      if (p >= from) chk(tag, ones - o0, exp_ones);
    end
  endtask

  initial begin
    bit     t;
    int     nx;
    int     xf;
    longint o0;
    ur_cnt = 0;

    repeat (3) @(negedge pdm_clk);
    chk("rst_pdm", pdm, 0);
    chk("rst_pcm_clk", pcm_clk, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", pcm_ready, 1);
    reset_n = 1'b1;
    model_reset();

    run_seg("dens_zero", 0, 4, 0, 32);
    run_seg("dens_min", -32768, 3, 1, 0);
    run_seg("dens_max", 32767, 4, 2, 64);
    run_seg("dens_half", 16384, 4, 1, 48);

    nx = 1000;
    for (int p = 0; p < 4; p++) begin
      xf = 0;
      for (int c = 0; c < D; c++) begin
        tick(1'b1, nx, t);
        if (t) begin
          xf++;
          nx += 1000;
        end
      end
      chk("xfer_per_period", xf, 1);
    end

    tick(1'b1, 8192, t);
    chk("single_accept", t, 1);
    for (int c = 1; c < D; c++) tick(1'b0, 0, t);
    for (int p = 0; p < 3; p++) begin
      o0     = ones;
      ur_cnt = 0;
      for (int c = 0; c < D; c++) tick(1'b0, 0, t);
      chk("dens_hold", ones - o0, 40);
      chk("ur_per_period", ur_cnt, 1);
    end

    tick(1'b1, 12345, t);
    for (int c = 1; c < 20; c++) tick(1'b0, 0, t);
    chk("pre_rst_full", pcm_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pdm", pdm, 0);
    chk("arst_pcm_clk", pcm_clk, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_ready", pcm_ready, 1);
    @(negedge pdm_clk);
    @(negedge pdm_clk);
    reset_n = 1'b1;
    model_reset();
    for (int p = 0; p < 2; p++) begin
      o0     = ones;
      ur_cnt = 0;
      for (int c = 0; c < D; c++) tick(1'b0, 0, t);
      chk("post_rst_dens", ones - o0, 32);
      chk("post_rst_ur", ur_cnt, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
